instr_fetch_queue: RTL

//   Fetch stage and prefetch FIFO in front of the IF/ID pipeline register. Owns the fetch PC,

---
 rtl/instr_fetch_queue_if.sv | 60 ++++++
 rtl/instr_fetch_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/instr_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue_if
//   Bundles the fetch-queue signals: the instruction-memory address/data pair,
//   the branch redirect from EX/MEM, the decode dequeue handshake and the head
//   entry presented to the IF/ID register.
//
//   slave  modport : the fetch queue itself
//   master modport : the environment (memory, EX/MEM, decode)
//
//   Signals
//     startpc     fetch PC loaded while reset is high
//     imem_addr   instruction-memory address (= fetch PC)
//     imem_data   instruction at imem_addr, same cycle
//     redirect    branch taken: flush and refetch at redirect_pc
//     redirect_pc redirect target
//     deq         decode accepts the head entry
//     out_valid   head entry valid
//     out_instr   head instruction (0 when !out_valid)
//     out_pc      head PC (0 when !out_valid)
//     count       occupied entries
//     flush_count / full_stalls   only when IFQ_PERF_EN is defined
// ----------------------------------------------------------------------------
interface instr_fetch_queue_if #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  startpc;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               deq;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [CNT_W-1:0]   count;
`ifdef IFQ_PERF_EN
    logic [31:0]        flush_count;
    logic [31:0]        full_stalls;
`endif

    modport slave (
        input  startpc, imem_data, redirect, redirect_pc, deq,
        output imem_addr, out_valid, out_instr, out_pc, count
`ifdef IFQ_PERF_EN
        , output flush_count, full_stalls
`endif
    );

    modport master (
        output startpc, imem_data, redirect, redirect_pc, deq,
        input  imem_addr, out_valid, out_instr, out_pc, count
`ifdef IFQ_PERF_EN
        , input flush_count, full_stalls
`endif
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//   Fetch stage plus prefetch FIFO in front of the IF/ID register. Owns the
//   fetch PC, drives the combinational instruction-memory address and buffers
//   {pc, instruction} pairs. Decode pops the head with deq; a branch redirect
//   flushes the queue and restarts fetch at the target.
//
//   Ports
//     CLK    clock, all state on posedge
//     reset  synchronous, active-high
//     bus    instr_fetch_queue_if.slave (memory, redirect, decode handshake)
//
//   Optional feature macro: IFQ_PERF_EN
//     Adds saturating 32-bit flush_count and full_stalls counters on the bus.
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input logic                    CLK,
    input logic                    reset,
    instr_fetch_queue_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];

    logic               w_head_vld;
    logic               w_not_full;
    logic               w_pop;
    logic               w_push;
    logic [CNT_W-1:0]   w_count_next;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_head_vld = (r_count != '0);
    assign w_not_full = (r_count != CNT_W'(DEPTH));
    // Redirect suppresses both sides; a full queue may still push when the
    // head leaves in the same cycle.
    assign w_pop      = bus.deq && w_head_vld && !bus.redirect;
    assign w_push     = !bus.redirect && (w_not_full || w_pop);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Control state: fetch PC, pointers, occupancy
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_fetch_pc <= bus.startpc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Entry storage is data only; stale contents after a flush are never
    // visible because occupancy gates the outputs.
    always_ff @(posedge CLK) begin
        if (!reset && w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_instr[r_wr_ptr] <= bus.imem_data;
        end
    end

    assign bus.imem_addr = r_fetch_pc;
    assign bus.out_valid = w_head_vld;
    assign bus.out_instr = w_head_vld ? r_mem_instr[r_rd_ptr] : '0;
    assign bus.out_pc    = w_head_vld ? r_mem_pc[r_rd_ptr]    : '0;
    assign bus.count     = r_count;

`ifdef IFQ_PERF_EN
    logic [31:0] r_flush_count;
    logic [31:0] r_full_stalls;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_flush_count <= '0;
            r_full_stalls <= '0;
        end else begin
            if (bus.redirect) begin
                r_flush_count <= sat_inc32(r_flush_count);
            end
            if (!w_not_full && !bus.deq && !bus.redirect) begin
                r_full_stalls <= sat_inc32(r_full_stalls);
            end
        end
    end

    assign bus.flush_count = r_flush_count;
    assign bus.full_stalls = r_full_stalls;
`endif

endmodule
